// File: rtl/ctrl_stack_if.sv
// Op handshake and status bundle between the core FSM and ctrl_stack_unit.
// The core drives the master side; the stack engine implements the slave side.
interface ctrl_stack_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CDEPTH = 4
);
  localparam int unsigned CW = $clog2(CDEPTH + 1);

  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] push_addr;
  logic             en;
  logic [WIDTH-1:0] ret_addr;
  logic             ret_valid;
  logic             ret_taken;
  logic [CW-1:0]    cdepth;
  logic             overflow;
  logic             underflow;
  logic             err_clr;

  modport master (
    output op_valid, op, push_addr, err_clr,
    input  op_ready, en, ret_addr, ret_valid, ret_taken, cdepth, overflow, underflow
  );

  modport slave (
    input  op_valid, op, push_addr, err_clr,
    output op_ready, en, ret_addr, ret_valid, ret_taken, cdepth, overflow, underflow
  );
endinterface

// File: rtl/ctrl_stack_unit.sv
// Call/return stack and enable-mask stack for the multicycle core, with occupancy
// tracking, sticky overflow/underflow flags and a one-cycle RET response phase.
module ctrl_stack_unit #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CDEPTH = 4,
  parameter int unsigned EDEPTH = 32
) (
  input logic         clk,
  input logic         reset,
  ctrl_stack_if.slave bus
);
  localparam int unsigned CW = $clog2(CDEPTH + 1);
  localparam int unsigned EW = $clog2(EDEPTH + 1);
  localparam logic [CW-1:0] CFull = CW'(CDEPTH);
  localparam logic [EW-1:0] EFull = EW'(EDEPTH);
  localparam logic [EW-1:0] EOne  = EW'(1);

  typedef enum logic [2:0] {
    OpNop, OpCall, OpRet, OpPushEn, OpPopEn, OpAllEn, OpClrEn, OpRsvd
  } op_e;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cstk_q [CDEPTH];
  logic [WIDTH-1:0] cstk_d [CDEPTH];
  logic [CW-1:0]    cdepth_q, cdepth_d;
  // Bit 0 is the top of the enable stack; slots beyond the occupancy always hold 1.
  logic [EDEPTH-1:0] estk_q, estk_d;
  logic [EW-1:0]    eocc_q, eocc_d;
  logic [WIDTH-1:0] ret_addr_q, ret_addr_d;
  logic             ret_taken_q, ret_taken_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             accept;
  logic             en_top;

  assign en_top = estk_q[0];
  assign accept = bus.op_valid & (state_q == StIdle);

  always_comb begin
    state_d     = state_q;
    cstk_d      = cstk_q;
    cdepth_d    = cdepth_q;
    estk_d      = estk_q;
    eocc_d      = eocc_q;
    ret_addr_d  = ret_addr_q;
    ret_taken_d = ret_taken_q;
    // A set later in this block overrides the clear on the same edge.
    overflow_d  = overflow_q & ~bus.err_clr;
    underflow_d = underflow_q & ~bus.err_clr;

    if (state_q == StResp) state_d = StIdle;

    if (accept) begin
      case (op_e'(bus.op))
        OpCall: begin
          if (en_top) begin
            for (int i = CDEPTH - 1; i > 0; i--) cstk_d[i] = cstk_q[i-1];
            cstk_d[0] = bus.push_addr;
            if (cdepth_q == CFull) overflow_d = 1'b1;
            else                   cdepth_d   = cdepth_q + 1'b1;
          end
        end
        OpRet: begin
          state_d     = StResp;
          ret_addr_d  = '0;
          ret_taken_d = 1'b0;
          if (en_top) begin
            if (cdepth_q != '0) begin
              ret_addr_d  = cstk_q[0];
              ret_taken_d = 1'b1;
              for (int i = 0; i < CDEPTH - 1; i++) cstk_d[i] = cstk_q[i+1];
              cstk_d[CDEPTH-1] = '0;
              cdepth_d = cdepth_q - 1'b1;
            end else begin
              underflow_d = 1'b1;
            end
          end
        end
        OpPushEn: begin
          estk_d = {estk_q[EDEPTH-2:0], estk_q[0]};
          if (eocc_q == EFull) overflow_d = 1'b1;
          else                 eocc_d     = eocc_q + 1'b1;
        end
        OpPopEn: begin
          if (eocc_q == EOne) begin
            estk_d[0]   = 1'b1;
            underflow_d = 1'b1;
          end else begin
            estk_d = {1'b1, estk_q[EDEPTH-1:1]};
            eocc_d = eocc_q - 1'b1;
          end
        end
        OpAllEn: estk_d[0] = 1'b1;
        OpClrEn: estk_d[0] = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      for (int i = 0; i < CDEPTH; i++) cstk_q[i] <= '0;
      cdepth_q    <= '0;
      estk_q      <= '1;
      eocc_q      <= EOne;
      ret_addr_q  <= '0;
      ret_taken_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cstk_q      <= cstk_d;
      cdepth_q    <= cdepth_d;
      estk_q      <= estk_d;
      eocc_q      <= eocc_d;
      ret_addr_q  <= ret_addr_d;
      ret_taken_q <= ret_taken_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.op_ready  = (state_q == StIdle);
  assign bus.ret_valid = (state_q == StResp);
  assign bus.en        = en_top;
  assign bus.ret_addr  = ret_addr_q;
  assign bus.ret_taken = ret_taken_q;
  assign bus.cdepth    = cdepth_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_ctrl_stack_unit.sv
// Bench for ctrl_stack_unit: directed scenarios plus random ops, all checked
// against a queue-based reference model of the two stacks.
module tb_ctrl_stack_unit;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CDEPTH = 4;
  localparam int unsigned EDEPTH = 32;

  localparam logic [2:0] OP_NOP = 3'd0, OP_CALL = 3'd1, OP_RET = 3'd2, OP_PUSHEN = 3'd3;
  localparam logic [2:0] OP_POPEN = 3'd4, OP_ALLEN = 3'd5, OP_CLREN = 3'd6, OP_RSVD = 3'd7;

  logic clk = 1'b0;
  logic reset = 1'b1;

  ctrl_stack_if #(.WIDTH(WIDTH), .CDEPTH(CDEPTH)) bus ();

  ctrl_stack_unit #(.WIDTH(WIDTH), .CDEPTH(CDEPTH), .EDEPTH(EDEPTH)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: front of each queue is the top of stack.
  logic [WIDTH-1:0] cq[$];
  bit               eq[$];
  bit               m_resp;
  bit               m_taken;
  bit               m_ov;
  bit               m_un;
  logic [WIDTH-1:0] m_ret;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cq.delete();
    eq.delete();
    eq.push_back(1'b1);
    m_resp  = 1'b0;
    m_taken = 1'b0;
    m_ov    = 1'b0;
    m_un    = 1'b0;
    m_ret   = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".op_ready"},  32'(bus.op_ready),  32'(!m_resp));
    check({tag, ".ret_valid"}, 32'(bus.ret_valid), 32'(m_resp));
    check({tag, ".en"},        32'(bus.en),        32'(eq[0]));
    check({tag, ".cdepth"},    32'(bus.cdepth),    32'(cq.size()));
    check({tag, ".ret_addr"},  32'(bus.ret_addr),  32'(m_ret));
    check({tag, ".overflow"},  32'(bus.overflow),  32'(m_ov));
    check({tag, ".underflow"}, 32'(bus.underflow), 32'(m_un));
    if (m_resp) check({tag, ".ret_taken"}, 32'(bus.ret_taken), 32'(m_taken));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, compare everything.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] addr,
                       input bit valid, input bit clr);
    bit acc, ovs, uns;
    @(negedge clk);
    bus.op_valid  = valid;
    bus.op        = op;
    bus.push_addr = addr;
    bus.err_clr   = clr;
    acc = valid && !m_resp;
    @(posedge clk);
    #1;
    m_resp = 1'b0;
    ovs    = 1'b0;
    uns    = 1'b0;
    if (acc) begin
      case (op)
        OP_CALL: if (eq[0]) begin
          cq.push_front(addr);
          if (cq.size() > CDEPTH) begin
            void'(cq.pop_back());
            ovs = 1'b1;
          end
        end
        OP_RET: begin
          m_resp  = 1'b1;
          m_ret   = '0;
          m_taken = 1'b0;
          if (eq[0]) begin
            if (cq.size() > 0) begin
              m_ret   = cq.pop_front();
              m_taken = 1'b1;
            end else begin
              uns = 1'b1;
            end
          end
        end
        OP_PUSHEN: begin
          eq.push_front(eq[0]);
          if (eq.size() > EDEPTH) begin
            void'(eq.pop_back());
            ovs = 1'b1;
          end
        end
        OP_POPEN: begin
          if (eq.size() > 1) void'(eq.pop_front());
          else begin
            eq[0] = 1'b1;
            uns   = 1'b1;
          end
        end
        OP_ALLEN: eq[0] = 1'b1;
        OP_CLREN: eq[0] = 1'b0;
        default: ;
      endcase
    end
    m_ov = (m_ov && !clr) || ovs;
    m_un = (m_un && !clr) || uns;
    bus.op_valid = 1'b0;
    bus.err_clr  = 1'b0;
    check_all(tag);
  endtask

  initial begin
    logic [2:0] rop;
    bus.op_valid  = 1'b0;
    bus.op        = OP_NOP;
    bus.push_addr = '0;
    bus.err_clr   = 1'b0;
    model_reset();
    #12 reset = 1'b0;
    #1;
    // T1
    check_all("t1");
    check("t1_en_const", 32'(bus.en), 32'd1);

    // T2
    do_op("t2_call", OP_CALL, 16'h0010, 1'b1, 1'b0);
    do_op("t2_call", OP_CALL, 16'h0020, 1'b1, 1'b0);
    do_op("t2_ret", OP_RET, '0, 1'b1, 1'b0);
    check("t2_ret1_const", 32'(bus.ret_addr), 32'h0020);
    do_op("t2_idle", OP_NOP, '0, 1'b0, 1'b0);
    do_op("t2_ret", OP_RET, '0, 1'b1, 1'b0);
    check("t2_ret2_const", 32'(bus.ret_addr), 32'h0010);
    check("t2_cdepth_const", 32'(bus.cdepth), 32'd0);
    // Op offered during RESP must be ignored.
    do_op("t2_busy", OP_CALL, 16'h0099, 1'b1, 1'b0);

    // T3
    for (int i = 1; i <= 5; i++) do_op("t3_call", OP_CALL, WIDTH'(i), 1'b1, 1'b0);
    check("t3_ovf_const", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 5; i++) begin
      do_op("t3_ret", OP_RET, '0, 1'b1, 1'b0);
      do_op("t3_gap", OP_NOP, '0, 1'b1, 1'b0);
    end
    check("t3_unf_const", 32'(bus.underflow), 32'd1);
    do_op("t3_clr", OP_NOP, '0, 1'b0, 1'b1);

    // T4
    do_op("t4_push", OP_PUSHEN, '0, 1'b1, 1'b0);
    do_op("t4_clr", OP_CLREN, '0, 1'b1, 1'b0);
    do_op("t4_call", OP_CALL, 16'h0033, 1'b1, 1'b0);
    do_op("t4_ret", OP_RET, '0, 1'b1, 1'b0);
    do_op("t4_gap", OP_NOP, '0, 1'b0, 1'b0);
    do_op("t4_pop", OP_POPEN, '0, 1'b1, 1'b0);
    do_op("t4_call", OP_CALL, 16'h0033, 1'b1, 1'b0);
    check("t4_cdepth_const", 32'(bus.cdepth), 32'd1);

    // T5
    do_op("t5_pop", OP_POPEN, '0, 1'b1, 1'b0);
    do_op("t5_popclr", OP_POPEN, '0, 1'b1, 1'b1);
    check("t5_unf_hold_const", 32'(bus.underflow), 32'd1);
    do_op("t5_clr", OP_NOP, '0, 1'b0, 1'b1);
    check("t5_unf_clr_const", 32'(bus.underflow), 32'd0);

    // T6
    do_op("t6_clren", OP_CLREN, '0, 1'b1, 1'b0);
    do_op("t6_ret", OP_RET, '0, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check("t6_op_ready", 32'(bus.op_ready), 32'd1);
    check("t6_ret_valid", 32'(bus.ret_valid), 32'd0);
    check("t6_cdepth", 32'(bus.cdepth), 32'd0);
    check("t6_en", 32'(bus.en), 32'd1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all("t6_after");

    // Random phase: first half leans on PUSHEN to reach enable-stack full, second on POPEN.
    for (int n = 0; n < 3000; n++) begin
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 3) rop = (n < 1500) ? OP_PUSHEN : OP_POPEN;
      do_op("rnd", rop, 16'($urandom()), $urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
